// File: rtl/haar_stage_scheduler.sv
// haar_stage_scheduler
//   Runs the Haar cascade for one candidate window at a time. Stages are
//   launched in order (one-cycle start pulse each) and the scheduler waits for
//   the launched stage's verdict. The first reject ends the window early, and
//   so does a stage that stays silent for TIMEOUT cycles. Each window produces
//   exactly one face / no-face result, held until the consumer takes it.
//   Saturating counters record the delivered faces and rejects.
// Ports
//   clk_fpga, reset_fpga         clock (rising edge), async active-low reset
//   cand_valid/ready/index       candidate window handshake, index latched on accept
//   stage_start                  one-hot start pulse to the stage classifiers
//   stage_done/pass              per-stage verdict strobe and verdict
//   res_valid/ready              result handshake
//   res_index/face/stage/timeout result fields, stable while res_valid is high
//   busy                         scheduler not idle
//   face_count, reject_count     saturating delivered-result statistics
module haar_stage_scheduler #(
  parameter int DATA_WIDTH_16 = 16,
  parameter int NUM_STAGES    = 10,
  parameter int STAGE_W       = 4,
  parameter int TIMEOUT       = 1023,
  parameter int TIMEOUT_W     = 10
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     cand_valid,
  output logic                     cand_ready,
  input  logic [DATA_WIDTH_16-1:0] cand_index,
  output logic [NUM_STAGES-1:0]    stage_start,
  input  logic [NUM_STAGES-1:0]    stage_done,
  input  logic [NUM_STAGES-1:0]    stage_pass,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_WIDTH_16-1:0] res_index,
  output logic                     res_face,
  output logic [STAGE_W-1:0]       res_stage,
  output logic                     res_timeout,
  output logic                     busy,
  output logic [DATA_WIDTH_16-1:0] face_count,
  output logic [DATA_WIDTH_16-1:0] reject_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_REPORT = 2'd3;

  localparam logic [STAGE_W-1:0]   LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST   = TIMEOUT_W'(TIMEOUT - 1);

  logic [1:0]               state_q, state_d;
  logic [STAGE_W-1:0]       stage_q, stage_d;
  logic [TIMEOUT_W-1:0]     timer_q, timer_d;
  logic [DATA_WIDTH_16-1:0] index_q, index_d;
  logic                     face_q, face_d;
  logic                     tmo_q, tmo_d;
  logic [DATA_WIDTH_16-1:0] fcnt_q, fcnt_d;
  logic [DATA_WIDTH_16-1:0] rcnt_q, rcnt_d;

  // One-hot decode of the current stage; it selects which done/pass bit is
  // honoured and doubles as the start pulse pattern.
  logic [NUM_STAGES-1:0] stage_sel;
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_sel
    assign stage_sel[gi] = (stage_q == STAGE_W'(gi));
  end

  logic cur_done, cur_pass;
  assign cur_done = |(stage_done & stage_sel);
  assign cur_pass = |(stage_pass & stage_sel);

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    timer_d = timer_q;
    index_d = index_q;
    face_d  = face_q;
    tmo_d   = tmo_q;
    fcnt_d  = fcnt_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      S_IDLE: begin
        if (cand_valid) begin
          index_d = cand_index;
          stage_d = '0;
          face_d  = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TIMEOUT_W'(1);
        // A verdict in the final timer cycle still counts; timeout only
        // applies when nothing arrived.
        if (cur_done) begin
          if (!cur_pass) begin
            state_d = S_REPORT;
          end else if (stage_q == LAST_STAGE) begin
            face_d  = 1'b1;
            state_d = S_REPORT;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            state_d = S_LAUNCH;
          end
        end else if (timer_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_REPORT;
        end
      end
      default: begin
        if (res_ready) begin
          if (face_q) begin
            if (!(&fcnt_q)) fcnt_d = fcnt_q + DATA_WIDTH_16'(1);
          end else begin
            if (!(&rcnt_q)) rcnt_d = rcnt_q + DATA_WIDTH_16'(1);
          end
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_fpga or negedge reset_fpga) begin
    if (!reset_fpga) begin
      state_q <= S_IDLE;
      stage_q <= '0;
      timer_q <= '0;
      index_q <= '0;
      face_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fcnt_q  <= '0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      timer_q <= timer_d;
      index_q <= index_d;
      face_q  <= face_d;
      tmo_q   <= tmo_d;
      fcnt_q  <= fcnt_d;
      rcnt_q  <= rcnt_d;
    end
  end

  // cand_ready is qualified with the reset so every output reads 0 while
  // reset is held, even though the state register rests in IDLE.
  assign cand_ready   = (state_q == S_IDLE) & reset_fpga;
  assign busy         = (state_q != S_IDLE);
  assign stage_start  = (state_q == S_LAUNCH) ? stage_sel : '0;
  assign res_valid    = (state_q == S_REPORT);
  assign res_index    = index_q;
  assign res_face     = face_q;
  assign res_stage    = stage_q;
  assign res_timeout  = tmo_q;
  assign face_count   = fcnt_q;
  assign reject_count = rcnt_q;

endmodule

// File: tb/tb_haar_stage_scheduler.sv
// Randomized bench for haar_stage_scheduler. Each window is planned up front
// (per-stage response delay and verdict). The expected timeline is derived from
// that plan with cycle arithmetic: start cycles, result cycle, outcome, and
// counters. A negedge process compares every output on every cycle.
module tb_haar_stage_scheduler;
  localparam int NS = 10;
  localparam int SW = 4;
  localparam int DW = 8;
  localparam int TO = 40;
  localparam int TW = 6;
  localparam int SATV = (1 << DW) - 1;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga = 1'b0;
  logic          cand_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic [DW-1:0] cand_index = '0;
  logic [NS-1:0] stage_done = '0;
  logic [NS-1:0] stage_pass = '0;
  logic [NS-1:0] stage_start;
  logic          cand_ready, res_valid, res_face, res_timeout, busy;
  logic [DW-1:0] res_index, face_count, reject_count;
  logic [SW-1:0] res_stage;

  always #5 clk_fpga = ~clk_fpga;

  haar_stage_scheduler #(
    .DATA_WIDTH_16(DW), .NUM_STAGES(NS), .STAGE_W(SW), .TIMEOUT(TO), .TIMEOUT_W(TW)
  ) dut (
    .clk_fpga(clk_fpga), .reset_fpga(reset_fpga),
    .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_index(cand_index),
    .stage_start(stage_start), .stage_done(stage_done), .stage_pass(stage_pass),
    .res_valid(res_valid), .res_ready(res_ready), .res_index(res_index),
    .res_face(res_face), .res_stage(res_stage), .res_timeout(res_timeout),
    .busy(busy), .face_count(face_count), .reject_count(reject_count)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the current cycle.
  logic          e_ready, e_busy, e_rvalid, e_face, e_tmo;
  logic [NS-1:0] e_start;
  logic [DW-1:0] e_index;
  int            e_stage;
  int            m_faces = 0;
  int            m_rejects = 0;

  // Plan for the next window: response delay in WAIT cycles (>= TO: never).
  int plan_dly[NS];
  bit plan_pass[NS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_fpga) begin
    if (chk_en) begin
      check("cand_ready", 64'(cand_ready), 64'(e_ready));
      check("busy", 64'(busy), 64'(e_busy));
      check("stage_start", 64'(stage_start), 64'(e_start));
      check("res_valid", 64'(res_valid), 64'(e_rvalid));
      check("face_count", 64'(face_count), 64'(m_faces));
      check("reject_count", 64'(reject_count), 64'(m_rejects));
      if (e_rvalid) begin
        check("res_index", 64'(res_index), 64'(e_index));
        check("res_face", 64'(res_face), 64'(e_face));
        check("res_stage", 64'(res_stage), 64'(e_stage));
        check("res_timeout", 64'(res_timeout), 64'(e_tmo));
      end
    end
  end

  task automatic set_idle_exp();
    e_ready = 1'b1; e_busy = 1'b0; e_rvalid = 1'b0; e_start = '0;
  endtask

  task automatic plan_all(input int d);
    for (int k = 0; k < NS; k++) begin
      plan_dly[k] = d;
      plan_pass[k] = 1'b1;
    end
  endtask

  task automatic plan_random();
    for (int k = 0; k < NS; k++) begin
      int r;
      r = int'($urandom_range(99));
      if (r < 4) plan_dly[k] = TO + int'($urandom_range(3));
      else if (r < 8) plan_dly[k] = TO - 1;
      else plan_dly[k] = int'($urandom_range(4));
      plan_pass[k] = ($urandom_range(99) < 92);
    end
  endtask

  // Runs one window. Relative cycle 0 is the accept cycle. r_res returns the
  // relative cycle in which res_valid is expected (-1 if reset intervened).
  task automatic run_window(input logic [DW-1:0] idx, input int hold, input int gap,
                            input bit rst5, input int stray_pct, output int r_res);
    int st[NS];
    int dc[NS];
    int last, rr, rs, wk, whi;
    bit face, tmo;
    rs = 1; face = 1'b0; tmo = 1'b0; last = NS - 1; rr = 0;
    for (int k = 0; k < NS; k++) begin
      st[k] = rs;
      dc[k] = -1;
      if (plan_dly[k] >= TO) begin
        rr = rs + TO + 1; tmo = 1'b1; last = k; break;
      end
      dc[k] = rs + 1 + plan_dly[k];
      if (!plan_pass[k] || k == NS - 1) begin
        rr = dc[k] + 1; face = plan_pass[k]; last = k; break;
      end
      rs = dc[k] + 1;
    end
    r_res = rr;
    for (int c = -gap; c <= rr + hold; c++) begin
      if (c < 0) begin
        cand_valid = 1'b0;
      end else if (c == 0) begin
        cand_valid = 1'b1; cand_index = idx;
      end else begin
        cand_valid = $urandom_range(1); cand_index = DW'($urandom);
      end
      stage_done = ($urandom_range(99) < stray_pct) ? NS'($urandom) : '0;
      stage_pass = NS'($urandom);
      wk = -1;
      for (int k = 0; k <= last; k++) begin
        whi = (dc[k] >= 0) ? dc[k] : st[k] + TO;
        if (c >= st[k] + 1 && c <= whi) wk = k;
      end
      if (wk >= 0) begin
        stage_done[wk] = (c == dc[wk]);
        if (c == dc[wk]) stage_pass[wk] = plan_pass[wk];
      end
      res_ready = (c >= rr) ? (c == rr + hold) : 1'($urandom_range(1));
      e_busy = (c >= 1);
      e_ready = !e_busy;
      e_start = '0;
      for (int k = 0; k <= last; k++) if (st[k] == c) e_start[k] = 1'b1;
      e_rvalid = (c >= rr);
      e_index = idx; e_face = face; e_stage = last; e_tmo = tmo;
      chk_en = 1'b1;
      if (rst5 && last >= 5 && c == st[5] + 2) begin
        chk_en = 1'b0;
        #2 reset_fpga = 1'b0;
        #1;
        check("rst_flags", 64'({cand_ready, busy, stage_start, res_valid, res_face, res_timeout}), 64'd0);
        check("rst_fields", 64'({res_index, res_stage}), 64'd0);
        check("rst_counts", 64'({face_count, reject_count}), 64'd0);
        @(posedge clk_fpga); #1;
        reset_fpga = 1'b1;
        m_faces = 0; m_rejects = 0;
        cand_valid = 1'b0; res_ready = 1'b0;
        stage_done = '1; stage_pass = '1;  // late verdicts after reset: ignored
        set_idle_exp();
        chk_en = 1'b1;
        @(posedge clk_fpga); #1;
        stage_done = '0;
        r_res = -1;
        return;
      end
      @(posedge clk_fpga); #1;
    end
    if (face) m_faces = (m_faces < SATV) ? m_faces + 1 : SATV;
    else m_rejects = (m_rejects < SATV) ? m_rejects + 1 : SATV;
    cand_valid = 1'b0; res_ready = 1'b0; stage_done = '0;
    set_idle_exp();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int r;
    #1;
    check("por_flags", 64'({cand_ready, busy, stage_start, res_valid}), 64'd0);
    check("por_counts", 64'({face_count, reject_count}), 64'd0);
    @(posedge clk_fpga); @(posedge clk_fpga); #1;
    reset_fpga = 1'b1;
    set_idle_exp();
    chk_en = 1'b1;

    // 1: all stages pass immediately
    plan_all(0);
    run_window(8'hA5, 0, 2, 1'b0, 0, r);
    $display("window all-pass: res_valid at cycle %0d", r);
    check("lat_allpass", 64'(r), 64'd21);
    check("t1_face_count", 64'(face_count), 64'd1);

    // 2: reject at stage 3
    plan_all(0); plan_pass[3] = 1'b0;
    run_window(8'h3C, 2, 1, 1'b0, 0, r);
    $display("window reject@3: res_valid at cycle %0d", r);
    check("lat_reject3", 64'(r), 64'd9);
    check("t2_reject_count", 64'(reject_count), 64'd1);

    // 3: stage 2 never answers; late stray verdicts arrive in REPORT
    plan_all(0); plan_dly[2] = TO + 5;
    run_window(8'h5A, 4, 0, 1'b0, 60, r);
    $display("window timeout@2: res_valid at cycle %0d", r);
    check("lat_timeout2", 64'(r), 64'(5 + TO + 1));
    check("t3_reject_count", 64'(reject_count), 64'd2);

    // 4: long backpressure with heavy stray verdict traffic
    plan_all(1);
    run_window(8'h77, 50, 3, 1'b0, 50, r);
    $display("window backpressure: res_valid at cycle %0d", r);

    // 5: reset in the middle of stage 5, then a clean window
    plan_all(1);
    run_window(8'h11, 0, 1, 1'b1, 20, r);
    $display("window reset@5: aborted");
    plan_all(0);
    run_window(8'h22, 1, 0, 1'b0, 20, r);
    $display("window after reset: res_valid at cycle %0d", r);
    check("t5_face_count", 64'(face_count), 64'd1);

    // 6: verdicts in the very last timer cycle win over the timeout
    plan_all(0); plan_dly[0] = TO - 1;
    run_window(8'h01, 0, 0, 1'b0, 10, r);
    $display("window coincide-pass: res_valid at cycle %0d", r);
    plan_all(0); plan_dly[1] = TO - 1; plan_pass[1] = 1'b0;
    run_window(8'h02, 0, 0, 1'b0, 10, r);
    $display("window coincide-reject: res_valid at cycle %0d", r);

    // Random windows
    for (int w = 0; w < 40; w++) begin
      plan_random();
      run_window(DW'($urandom), int'($urandom_range(5)), int'($urandom_range(3)), 1'b0, 25, r);
      $display("window random %0d: res_valid at cycle %0d", w, r);
    end

    // Saturation of face_count
    plan_all(0);
    for (int w = 0; w < SATV + 5; w++) run_window(DW'(w), 0, 0, 1'b0, 0, r);
    $display("window saturation run: %0d faces delivered", SATV + 5);
    check("face_sat", 64'(face_count), 64'(SATV));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
